// File: rtl/alu_mp_seq_pkg.sv
// rtl/alu_mp_seq_pkg.sv - shared constants and types for the multi-precision add/sub sequencer
package alu_mp_seq_pkg;

  localparam int SLICE_W = 16;

  // ALU_CC control lines as {sbb, sub, adc}; all low selects plain ADD
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Only the first slice may be a plain ADD/SUB; every later slice chains the carry
  function automatic logic [2:0] slice_op(input logic first, input logic use_cin,
                                          input logic sub);
    if (first && !use_cin) return sub ? OP_SUB : OP_ADD;
    return sub ? OP_SBB : OP_ADC;
  endfunction

endpackage

// File: rtl/alu_mp_seq_if.sv
// rtl/alu_mp_seq_if.sv - request/response bundle between control unit and the sequencer
interface alu_mp_seq_if #(
  parameter int WORDS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  op_sub;
  logic                  use_cin;
  logic [16*WORDS-1:0]   a;
  logic [16*WORDS-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [16*WORDS-1:0]   y;
  logic                  cc_n;
  logic                  cc_z;
  logic                  cc_c;
  logic                  cc_v;

  modport master (
    output in_valid, op_sub, use_cin, a, b, out_ready,
    input  in_ready, out_valid, y, cc_n, cc_z, cc_c, cc_v
  );

  modport slave (
    input  in_valid, op_sub, use_cin, a, b, out_ready,
    output in_ready, out_valid, y, cc_n, cc_z, cc_c, cc_v
  );
endinterface

// File: rtl/alu_mp_seq_alu.sv
// rtl/alu_mp_seq_alu.sv - 16-bit ALU_CC slice: add/sub with carry chaining and NZCV
module alu_mp_seq_alu
  import alu_mp_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [2:0]         ctrl,
  input  logic               pre_c,
  output logic [SLICE_W-1:0] y,
  output logic               n,
  output logic               z,
  output logic               c,
  output logic               v
);
  logic               is_adc;
  logic               is_sub;
  logic               is_sbb;
  logic [SLICE_W-1:0] b_eff;
  logic               cin;
  logic [SLICE_W:0]   sum;

  assign is_adc = (ctrl == OP_ADC);
  assign is_sub = (ctrl == OP_SUB);
  assign is_sbb = (ctrl == OP_SBB);

  // Subtract is A + ~B + cin, so C=1 means no borrow
  assign b_eff = (is_sub || is_sbb) ? ~b : b;
  assign cin   = is_sub ? 1'b1 : ((is_adc || is_sbb) ? pre_c : 1'b0);
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};

  assign y = sum[SLICE_W-1:0];
  assign n = sum[SLICE_W-1];
  assign z = (sum[SLICE_W-1:0] == '0);
  assign c = sum[SLICE_W];
  assign v = (a[SLICE_W-1] == b_eff[SLICE_W-1]) && (sum[SLICE_W-1] != a[SLICE_W-1]);

endmodule

// File: rtl/alu_mp_seq.sv
// rtl/alu_mp_seq.sv - sequences a WORDS*16-bit add/sub through one shared ALU_CC, LS slice first
module alu_mp_seq
  import alu_mp_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input logic          clk,
  input logic          rst,
  alu_mp_seq_if.slave  bus
);
  localparam int W     = SLICE_W * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     y_r;
  logic [W-1:0]     y_next;
  logic             op_sub_r;
  logic             use_cin_r;
  logic             carry_r;
  logic             z_acc;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             cc_n_r, cc_z_r, cc_c_r, cc_v_r;

  logic               first;
  logic [2:0]         alu_ctrl;
  logic               alu_pre_c;
  logic [SLICE_W-1:0] alu_y;
  logic               alu_n, alu_z, alu_c, alu_v;

  assign first     = (cnt == '0);
  assign alu_ctrl  = slice_op(first, use_cin_r, op_sub_r);
  assign alu_pre_c = first ? cc_c_r : carry_r;

  alu_mp_seq_alu u_alu (
    .a     (a_r[SLICE_W-1:0]),
    .b     (b_r[SLICE_W-1:0]),
    .ctrl  (alu_ctrl),
    .pre_c (alu_pre_c),
    .y     (alu_y),
    .n     (alu_n),
    .z     (alu_z),
    .c     (alu_c),
    .v     (alu_v)
  );

  // Result fills from the top down so after WORDS slices slice 0 sits at the bottom
  generate
    if (WORDS == 1) begin : g_y_one
      assign y_next = alu_y;
    end else begin : g_y_many
      assign y_next = {alu_y, y_r[W-1:SLICE_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      y_r         <= '0;
      op_sub_r    <= 1'b0;
      use_cin_r   <= 1'b0;
      carry_r     <= 1'b0;
      z_acc       <= 1'b1;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      cc_n_r      <= 1'b0;
      cc_z_r      <= 1'b0;
      cc_c_r      <= 1'b0;
      cc_v_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            op_sub_r   <= bus.op_sub;
            use_cin_r  <= bus.use_cin;
            cnt        <= '0;
            z_acc      <= 1'b1;
            in_ready_r <= 1'b0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          a_r     <= a_r >> SLICE_W;
          b_r     <= b_r >> SLICE_W;
          y_r     <= y_next;
          carry_r <= alu_c;
          z_acc   <= z_acc & alu_z;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            cc_n_r      <= alu_n;
            cc_z_r      <= z_acc & alu_z;
            cc_c_r      <= alu_c;
            cc_v_r      <= alu_v;
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = y_r;
  assign bus.cc_n      = cc_n_r;
  assign bus.cc_z      = cc_z_r;
  assign bus.cc_c      = cc_c_r;
  assign bus.cc_v      = cc_v_r;

endmodule

// File: tb/tb_alu_mp_seq.sv
// tb/tb_alu_mp_seq.sv - directed self-checking bench for alu_mp_seq with WORDS=2
module tb_alu_mp_seq;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_mp_seq_if #(.WORDS(2)) bus ();

  alu_mp_seq #(.WORDS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] flags();
    return {bus.cc_n, bus.cc_z, bus.cc_c, bus.cc_v};
  endfunction

  // Presents one request, returns once out_valid is seen (or after a bounded wait)
  task automatic do_op(input logic sub, input logic cin, input logic [31:0] av,
                       input logic [31:0] bv, output int lat);
    bus.op_sub   = sub;
    bus.use_cin  = cin;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.y !== 32'h0) begin errors++; $display("FAIL reset_y got=%h exp=00000000", bus.y); end
    checks++; if (flags() !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flags()); end
  endtask

  task automatic test_add();
    int lat;
    do_op(1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL add1_latency got=%0d exp=2", lat); end
    checks++; if (bus.y !== 32'h00010000) begin errors++; $display("FAIL add1_y got=%h exp=00010000", bus.y); end
    checks++; if (flags() !== 4'b0000) begin errors++; $display("FAIL add1_nzcv got=%b exp=0000", flags()); end
    release_result();
    do_op(1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, lat);
    checks++; if (bus.y !== 32'h80000000) begin errors++; $display("FAIL add2_y got=%h exp=80000000", bus.y); end
    checks++; if (flags() !== 4'b1001) begin errors++; $display("FAIL add2_nzcv got=%b exp=1001", flags()); end
    release_result();
    do_op(1'b0, 1'b0, 32'h00010000, 32'hFFFF0000, lat);
    checks++; if (bus.y !== 32'h0) begin errors++; $display("FAIL add3_y got=%h exp=00000000", bus.y); end
    checks++; if (flags() !== 4'b0110) begin errors++; $display("FAIL add3_nzcv got=%b exp=0110", flags()); end
    release_result();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL add_release got in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_sub();
    int lat;
    do_op(1'b1, 1'b0, 32'h00010000, 32'h00000001, lat);
    checks++; if (bus.y !== 32'h0000FFFF) begin errors++; $display("FAIL sub1_y got=%h exp=0000ffff", bus.y); end
    checks++; if (flags() !== 4'b0010) begin errors++; $display("FAIL sub1_nzcv got=%b exp=0010", flags()); end
    release_result();
    do_op(1'b1, 1'b0, 32'h00000005, 32'h00000005, lat);
    checks++; if (bus.y !== 32'h0) begin errors++; $display("FAIL sub2_y got=%h exp=00000000", bus.y); end
    checks++; if (flags() !== 4'b0110) begin errors++; $display("FAIL sub2_nzcv got=%b exp=0110", flags()); end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bus.op_sub   = 1'b0;
    bus.use_cin  = 1'b0;
    bus.a        = 32'h12345678;
    bus.b        = 32'h00000001;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (flags() !== 4'b0000) begin errors++; $display("FAIL midrst_flags got=%b exp=0000", flags()); end
    checks++; if (bus.y !== 32'h0) begin errors++; $display("FAIL midrst_y got=%h exp=00000000", bus.y); end
    do_op(1'b0, 1'b0, 32'h0000FFFF, 32'h00000001, lat);
    checks++; if (lat !== 2 || bus.y !== 32'h00010000) begin
      errors++; $display("FAIL midrst_next_op got lat=%0d y=%h exp lat=2 y=00010000", lat, bus.y);
    end
    release_result();
  endtask

  task automatic test_use_cin();
    int lat;
    do_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, lat);
    checks++; if (bus.y !== 32'h0 || flags() !== 4'b0110) begin
      errors++; $display("FAIL cin_setup got y=%h nzcv=%b exp y=00000000 nzcv=0110", bus.y, flags());
    end
    release_result();
    do_op(1'b0, 1'b1, 32'h0, 32'h0, lat);
    checks++; if (bus.y !== 32'h00000001) begin errors++; $display("FAIL cin_y got=%h exp=00000001", bus.y); end
    checks++; if (flags() !== 4'b0000) begin errors++; $display("FAIL cin_nzcv got=%b exp=0000", flags()); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(1'b0, 1'b0, 32'h12345678, 32'h11111111, lat);
    bus.a        = 32'hDEADBEEF;
    bus.b        = 32'h00000001;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_hs[%0d] got out_valid=%b in_ready=%b exp 1/0", i, bus.out_valid, bus.in_ready);
      end
      checks++; if (bus.y !== 32'h23456789 || flags() !== 4'b0000) begin
        errors++; $display("FAIL bp_hold_data[%0d] got y=%h nzcv=%b exp y=23456789 nzcv=0000", i, bus.y, flags());
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL bp_no_queue[%0d] got out_valid=%b in_ready=%b exp 0/1", i, bus.out_valid, bus.in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_idle_out_ready();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL idle_out_ready[%0d] got out_valid=%b in_ready=%b exp 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.use_cin   = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_reset_mid_run();
    test_use_cin();
    test_backpressure();
    test_idle_out_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
